// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiply/divide unit with architectural HI/LO registers.
// Optional macro MULDIV_EARLY_EXIT_EN lets zero-operand multiplies and divide-by-zero skip RUN.
module muldiv_unit #(
  parameter int WIDTH           = 32,
  parameter int STEPS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             divzero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int ITER = WIDTH / STEPS_PER_CYCLE;
  localparam int CW   = $clog2(ITER + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FINISH} state_t;

  // Handshake: start is sampled only in S_IDLE; busy stays high from the
  // accepting edge until the result edge; done pulses for one cycle once
  // hi/lo hold the new result, and divzero is meaningful only alongside it.
  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] acc_h, acc_l, opb, a_raw;
  logic             is_div, neg_q, neg_r, dz;

  logic [WIDTH-1:0] mag_a, mag_b;
  logic             early;

  assign mag_a = (op[0] && a[WIDTH-1]) ? -a : a;
  assign mag_b = (op[0] && b[WIDTH-1]) ? -b : b;

`ifdef MULDIV_EARLY_EXIT_EN
  assign early = op[1] ? (b == '0) : ((a == '0) || (b == '0));
`else
  assign early = 1'b0;
`endif

  // STEPS_PER_CYCLE radix-2 steps: shift-add multiply or restoring divide.
  logic [WIDTH-1:0] nh, nl;
  logic [WIDTH:0]   sh, sum;

  always_comb begin
    nh  = acc_h;
    nl  = acc_l;
    sh  = '0;
    sum = '0;
    for (int i = 0; i < STEPS_PER_CYCLE; i++) begin
      if (is_div) begin
        sh = {nh, nl[WIDTH-1]};
        nl = nl << 1;
        if (sh >= {1'b0, opb}) begin
          nh    = sh[WIDTH-1:0] - opb;
          nl[0] = 1'b1;
        end else begin
          nh = sh[WIDTH-1:0];
        end
      end else begin
        sum = {1'b0, nh} + (nl[0] ? {1'b0, opb} : '0);
        nl  = {sum[0], nl[WIDTH-1:1]};
        nh  = sum[WIDTH:1];
      end
    end
  end

  logic [2*WIDTH-1:0] prod_u, prod_s;
  logic [WIDTH-1:0]   quo, rem;

  assign prod_u = {acc_h, acc_l};
  assign prod_s = neg_q ? -prod_u : prod_u;
  assign quo    = neg_q ? -acc_l : acc_l;
  assign rem    = neg_r ? -acc_h : acc_h;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= S_IDLE;
      cnt     <= '0;
      acc_h   <= '0;
      acc_l   <= '0;
      opb     <= '0;
      a_raw   <= '0;
      is_div  <= 1'b0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      dz      <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      divzero <= 1'b0;
      hi      <= '0;
      lo      <= '0;
    end else begin
      done    <= 1'b0;
      divzero <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            if (!op[2]) begin
              is_div <= op[1];
              neg_q  <= op[0] & (a[WIDTH-1] ^ b[WIDTH-1]);
              neg_r  <= op[0] & a[WIDTH-1];
              dz     <= op[1] & (b == '0);
              a_raw  <= a;
              acc_h  <= '0;
              cnt    <= CW'(ITER);
              busy   <= 1'b1;
              state  <= early ? S_FINISH : S_RUN;
              if (op[1]) begin
                acc_l <= mag_a;
                opb   <= mag_b;
              end else begin
                // An early-exit multiply must finish with a zero product.
                acc_l <= early ? '0 : mag_b;
                opb   <= mag_a;
              end
            end else if (op == 3'b100) begin
              hi <= a;
            end else if (op == 3'b101) begin
              lo <= a;
            end
          end
        end
        S_RUN: begin
          acc_h <= nh;
          acc_l <= nl;
          cnt   <= cnt - CW'(1);
          if (cnt == CW'(1)) state <= S_FINISH;
        end
        S_FINISH: begin
          if (is_div) begin
            if (dz) begin
              hi      <= a_raw;
              lo      <= '1;
              divzero <= 1'b1;
            end else begin
              hi <= rem;
              lo <= quo;
            end
          end else begin
            {hi, lo} <= prod_s;
          end
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Parametrised, iterative multiply/divide unit with architectural HI/LO registers, sitting beside the ALU in the execute stage.
- Supports MULT/MULTU/DIV/DIVU and MTHI/MTLO. MFHI/MFLO read the `hi`/`lo` outputs directly.
- Uses a start/busy/done handshake so the control unit can stall while an operation is in flight.
- Radix-2 shift-add / restoring-divide core.
- Unrollable: STEPS_PER_CYCLE iterations per clock.

Parameters:
- WIDTH, 32: operand width and width of each of HI and LO.
- STEPS_PER_CYCLE, 1: iteration steps per clock. Must divide WIDTH. Defines ITER = WIDTH/STEPS_PER_CYCLE.

Ports:
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  synchronous, active-low; 0 at a rising edge resets the block
- start  input  1  request; sampled only in IDLE
- op  input  3  000 MULTU, 001 MULT, 010 DIVU, 011 DIV, 100 MTHI, 101 MTLO, 110/111 reserved
- a  input  WIDTH  rs operand (multiplicand / dividend / MTHI / MTLO source)
- b  input  WIDTH  rt operand (multiplier / divisor)
- busy  output  1  high while a mul/div is in flight
- done  output  1  one-cycle pulse; HI/LO hold the new result
- divzero  output  1  valid with done; 1 when the divisor was 0
- hi  output  WIDTH  HI register
- lo  output  WIDTH  LO register

Behaviour:
- Reset (reset==0 at edge):
  - State goes to IDLE; `hi`=0, `lo`=0, `busy`=0, `done`=0, `divzero`=0.
  - Any operation in flight is abandoned with no done pulse.
  - Reset has priority over every other input.
- States: IDLE, RUN, FINISH.
- IDLE:
  - start=1 with op 000–011: latch operands and op. Signed ops take magnitudes of a and b and record result signs. Load counter=ITER; go to RUN; busy=1 after the edge.
  - start=1 with op 100/101: `hi` (resp. `lo`) <= a at that edge. Stay IDLE; busy and done stay 0.
  - start=1 with op 110/111: ignored, no state change.
  - start=0: hold.
- RUN:
  - Each edge performs STEPS_PER_CYCLE radix-2 steps and decrements the counter.
  - When the counter reaches 0, go to FINISH.
  - start is ignored.
  - `hi`/`lo` keep their old values throughout RUN.
- FINISH:
  - At the next edge, apply sign correction and write `hi`/`lo`.
  - done=1 and busy=0 for exactly one cycle after that edge; return to IDLE.
- Latency: start edge E0 → done visible after edge E(ITER+1). Default latency is 33 cycles.
- A start in the done cycle is accepted normally (state is already IDLE).
- Multiply results:
  - `{hi,lo}` = full 2*WIDTH product.
  - MULT is two's-complement signed; MULTU is unsigned.
- Divide results:
  - `lo` = quotient, `hi` = remainder.
  - DIV truncates toward zero; the remainder takes the sign of the dividend.
  - Signed MIN / −1: `lo`=MIN, `hi`=0, no error flag.
- Divide by zero (b==0):
  - `lo`=all ones, `hi`=a (raw operand), divzero=1 with done.
  - Latency is the same as a normal divide unless the optional feature is enabled.
- divzero is 0 for every multiply and for non-zero divisors.
- divzero is cleared whenever done is low.

Optional Feature:
- Macro: `MULDIV_EARLY_EXIT_EN`.
- Defined: the block skips RUN when either
  - a multiply has a or b equal to 0, or
  - a divide has b==0.
  
  It goes IDLE→FINISH, so done is visible after edge E1. Results are identical to the full-latency path (zero product; divide-by-zero values above).
- Undefined: every mul/div has fixed ITER+1 latency.

Test Plan:
- Full-width unsigned multiply: MULTU a=0xFFFFFFFF b=0xFFFFFFFF → busy for 33 cycles; done pulses once; hi=0xFFFFFFFE, lo=0x00000001, divzero=0.
- Signed multiply and divides, with a back-to-back start issued in each done cycle:
  - MULT a=0xFFFFFFFD (−3) b=7 → hi=0xFFFFFFFF, lo=0xFFFFFFEB.
  - DIV a=0xFFFFFFF9 (−7) b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - DIVU a=7 b=2 → lo=3, hi=1.
- Divide by zero: DIVU a=0x00001234 b=0 → lo=0xFFFFFFFF, hi=0x00001234, divzero=1 with done. Done after 33 cycles without the macro, after 1 cycle with `MULDIV_EARLY_EXIT_EN`.
- Busy/reset interaction:
  - MULTU in flight; at cycle 10 start=1 op=DIV → ignored.
  - At cycle 15 reset=0 for one edge → busy=0, hi=lo=0, no done ever pulses.
  - A subsequent MULTU 3×5 gives lo=15.
- Moves and signed overflow:
  - MTHI a=0xDEADBEEF then MTLO a=0x0BADF00D on consecutive cycles → each register updates at its edge; busy never rises.
  - DIV a=0x80000000 b=0xFFFFFFFF → lo=0x80000000, hi=0.
- Unrolled core: rerun the MULTU test with STEPS_PER_CYCLE=4 → identical hi/lo, done after 9 cycles.
